// File: rtl/alu_sequencer.sv
// Word-wide ALU built by stepping one external 4-bit combinational ALU slice
// across SLICES nibbles, least-significant first, with a registered carry chain.
module alu_sequencer #(
  parameter int unsigned SLICES = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [4*SLICES-1:0]   ReqA,
  input  logic [4*SLICES-1:0]   ReqB,
  input  logic [3:0]            ReqOp,
  input  logic                  ReqM,
  input  logic                  ReqCin,
  output logic                  RespValid,
  input  logic                  RespReady,
  output logic [4*SLICES-1:0]   Result,
  output logic                  ResultCout,
  output logic                  ResultEq,
  output logic                  ResultZero,
  output logic [3:0]            AluA,
  output logic [3:0]            AluB,
  output logic [3:0]            AluOp,
  output logic                  AluM,
  output logic                  AluCin,
  input  logic [3:0]            AluOut,
  input  logic                  AluEq,
  input  logic                  AluCout
);

  localparam int unsigned W  = 4 * SLICES;
  localparam int unsigned IW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic [3:0]      op_q;
  logic            m_q;
  logic            cin_q;
  logic            carry_q;
  logic            eq_q;
  logic            cout_q;
  logic            last_slice;

  assign last_slice = (idx == IW'(SLICES - 1));

  // Sequencer: accept, walk the slices, hold the response until taken.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_q     <= '0;
      m_q      <= 1'b0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      eq_q     <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            a_q      <= ReqA;
            b_q      <= ReqB;
            op_q     <= ReqOp;
            m_q      <= ReqM;
            cin_q    <= ReqCin;
            result_q <= '0;
            idx      <= '0;
            carry_q  <= 1'b0;
            eq_q     <= 1'b1;
            cout_q   <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          result_q[{idx, 2'b00} +: 4] <= AluOut;
          carry_q <= AluCout;
          eq_q    <= eq_q & AluEq;
          if (last_slice) begin
            // Logic ops have no meaningful carry, so the word carry is forced low.
            cout_q <= m_q ? 1'b0 : AluCout;
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (RespReady) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Slice drive decodes only from registers, so it is quiet outside RUN.
  always_comb begin
    AluA   = 4'h0;
    AluB   = 4'h0;
    AluOp  = 4'h0;
    AluM   = 1'b0;
    AluCin = 1'b0;
    if (state == RUN) begin
      AluA   = a_q[{idx, 2'b00} +: 4];
      AluB   = b_q[{idx, 2'b00} +: 4];
      AluOp  = op_q;
      AluM   = m_q;
      AluCin = (idx == '0) ? cin_q : carry_q;
    end
  end

  assign ReqReady   = (state == IDLE);
  assign RespValid  = (state == DONE);
  assign Result     = result_q;
  assign ResultCout = cout_q;
  assign ResultEq   = eq_q;
  assign ResultZero = (state == DONE) && (result_q == '0);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, reset/backpressure sequences
// and random operations checked against a word-level reference model.
module tb_alu_sequencer;

  localparam int unsigned SLICES = 4;
  localparam int unsigned W      = 4 * SLICES;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          ReqValid;
  logic          ReqReady;
  logic [W-1:0]  ReqA;
  logic [W-1:0]  ReqB;
  logic [3:0]    ReqOp;
  logic          ReqM;
  logic          ReqCin;
  logic          RespValid;
  logic          RespReady;
  logic [W-1:0]  Result;
  logic          ResultCout;
  logic          ResultEq;
  logic          ResultZero;
  logic [3:0]    AluA;
  logic [3:0]    AluB;
  logic [3:0]    AluOp;
  logic          AluM;
  logic          AluCin;
  logic [3:0]    AluOut;
  logic          AluEq;
  logic          AluCout;

  alu_sequencer #(.SLICES(SLICES)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqA(ReqA), .ReqB(ReqB),
    .ReqOp(ReqOp), .ReqM(ReqM), .ReqCin(ReqCin),
    .RespValid(RespValid), .RespReady(RespReady), .Result(Result),
    .ResultCout(ResultCout), .ResultEq(ResultEq), .ResultZero(ResultZero),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluM(AluM), .AluCin(AluCin),
    .AluOut(AluOut), .AluEq(AluEq), .AluCout(AluCout)
  );

  always #5 CLK = ~CLK;

  // External 4-bit slice: add when M=0, xor when M=1.
  always_comb begin
    logic [4:0] s;
    s = {1'b0, AluA} + {1'b0, AluB} + {4'b0, AluCin};
    if (AluM) begin
      AluOut  = AluA ^ AluB;
      AluCout = 1'b0;
    end else begin
      AluOut  = s[3:0];
      AluCout = s[4];
    end
    AluEq = (AluOut == 4'hF);
  end

  int n_checks = 0;
  int n_fail   = 0;
  longint last_acc = -1;

  typedef struct {
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              m;
    logic              cin;
    logic [W-1:0]      res;
    logic              cout;
    logic              eq;
    logic              zero;
    logic [SLICES-1:0] cins;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, {ReqReady, RespValid, Result, ResultCout, ResultEq, ResultZero,
               AluA, AluB, AluOp, AluM, AluCin}, {1'b1, 34'h0});
  endtask

  // Word-level reference: whole-word add or xor; carry into slice k is the
  // carry out of the low 4k bits of the same add.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input logic cin, output logic [W-1:0] er, output logic ec,
                       output logic eq, output logic ez, output logic [SLICES-1:0] cins);
    logic [W:0]  s;
    logic [63:0] mask;
    logic [63:0] t;
    s = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    er = m ? (a ^ b) : s[W-1:0];
    ec = m ? 1'b0 : s[W];
    eq = (er == {W{1'b1}});
    ez = (er == '0);
    for (int k = 0; k < int'(SLICES); k++) begin
      mask = (64'd1 << (4 * k)) - 64'd1;
      t = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
      cins[k] = m ? ((k == 0) ? cin : 1'b0) : t[4*k];
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input logic cin, input logic [W-1:0] er, input logic ec,
                       input logic eq, input logic ez, input logic [SLICES-1:0] ecins,
                       input int bp, input bit hold_valid);
    int k;
    logic early;
    logic [SLICES-1:0] cins;
    longint acc;
    k = 0;
    while (!ReqReady && k < 50) begin
      step();
      k++;
    end
    chk("req_ready", ReqReady, 1);
    ReqA = a; ReqB = b; ReqOp = 4'b1001; ReqM = m; ReqCin = cin; ReqValid = 1'b1;
    @(posedge CLK);
    acc = longint'($time);
    #1;
    if (last_acc >= 0) chk("issue_interval_ge6", 64'((acc - last_acc) >= 60), 1);
    last_acc = acc;
    // Scramble request inputs and toggle handshakes; none of it may matter now.
    ReqA = W'($urandom); ReqB = W'($urandom); ReqOp = 4'($urandom);
    ReqM = 1'($urandom); ReqCin = 1'($urandom);
    early = 1'b0;
    for (int s = 0; s < int'(SLICES); s++) begin
      cins[s] = AluCin;
      if (s == 0) chk("slice0_drive", {AluOp, AluM, AluA, AluB}, {4'b1001, m, a[3:0], b[3:0]});
      early |= RespValid;
      ReqValid  = 1'($urandom);
      RespReady = 1'($urandom);
      step();
    end
    RespReady = 1'b0;
    chk("latency", {early, RespValid}, 2'b01);
    chk("result", Result, er);
    chk("result_cout", ResultCout, ec);
    chk("result_eq", ResultEq, eq);
    chk("result_zero", ResultZero, ez);
    chk("alu_cin_trace", cins, ecins);
    for (int i = 0; i < bp; i++) begin
      ReqValid = hold_valid ? 1'b1 : 1'($urandom);
      step();
      chk("hold_stable", {RespValid, ReqReady, Result, ResultCout, ResultEq, ResultZero},
          {2'b10, er, ec, eq, ez});
    end
    ReqValid  = hold_valid;
    RespReady = 1'b1;
    step();
    RespReady = 1'b0;
    ReqValid  = 1'b0;
    chk("release_idle", {RespValid, ReqReady, AluA, AluB, AluOp, AluM, AluCin}, {2'b01, 14'h0});
  endtask

  initial begin
    logic [W-1:0] a, b, er;
    logic m, cin, ec, eq, ez, seen;
    logic [SLICES-1:0] cins;

    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 4'b0110};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b1110};
    tbl[2] = '{16'h1234, 16'hEDCB, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'b1111};
    tbl[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[6] = '{16'h5A5A, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'b0000};
    tbl[7] = '{16'h0FFF, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 4'b1111};

    RST_N = 1'b0; ReqValid = 1'b0; ReqA = '0; ReqB = '0; ReqOp = '0;
    ReqM = 1'b0; ReqCin = 1'b0; RespReady = 1'b0;
    #3;
    chk_reset_outs("reset_before_clk");
    ReqValid = 1'b1;
    RespReady = 1'b1;
    step();
    step();
    chk_reset_outs("reset_with_clk");
    ReqValid = 1'b0;
    RespReady = 1'b0;
    RST_N = 1'b1;

    // Directed vectors, first one issued on the first edge after reset release.
    foreach (tbl[i])
      do_op(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].cin, tbl[i].res, tbl[i].cout,
            tbl[i].eq, tbl[i].zero, tbl[i].cins, (i == 1) ? 2 : 0, 1'b0);

    // Long backpressure with ReqValid held high the whole time.
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 4'b0110, 10, 1'b1);
    do_op(16'h1234, 16'hEDCB, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'b0000, 0, 1'b0);

    // Reset in the middle of a run at slice 2.
    ReqA = 16'h7777; ReqB = 16'h1111; ReqOp = 4'b1001; ReqM = 1'b0; ReqCin = 1'b0;
    ReqValid = 1'b1;
    step();
    ReqValid = 1'b0;
    step();
    step();
    #2;
    RST_N = 1'b0;
    #1;
    chk_reset_outs("reset_mid_run_async");
    step();
    chk_reset_outs("reset_mid_run_held");
    RST_N = 1'b1;
    last_acc = -1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen |= RespValid;
    end
    chk("no_resp_after_reset", seen, 1'b0);
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 4'b0110, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      a = W'($urandom); b = W'($urandom); m = 1'($urandom); cin = 1'($urandom);
      model(a, b, m, cin, er, ec, eq, ez, cins);
      do_op(a, b, m, cin, er, ec, eq, ez, cins, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter SLICES, default 4, the number of 4-bit ALU slices per word; word width W = 4*SLICES.
REQ-002 SHALL have ports CLK in 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have RST_N in 1, the reset: asynchronous and active-low.
REQ-004 SHALL have ReqValid in 1; ReqReady out 1; ReqA in W; ReqB in W; ReqOp in 4; ReqM in 1; ReqCin in 1, forming the request channel.
REQ-005 SHALL have RespValid out 1; RespReady in 1; Result out W; ResultCout out 1; ResultEq out 1; ResultZero out 1, forming the response channel.
REQ-006 SHALL have AluA out 4; AluB out 4; AluOp out 4; AluM out 1; AluCin out 1, driving one external combinational 4-bit ALU slice.
REQ-007 SHALL have AluOut in 4; AluEq in 1; AluCout in 1, the same-cycle combinational response from that slice.

Function
REQ-008 SHALL implement states IDLE, RUN, DONE, with a slice counter idx of width ceil(log2(SLICES)).
REQ-009 ReqReady SHALL be 1 exactly when state is IDLE; a request is accepted on an edge where ReqValid and ReqReady are both 1.
REQ-010 On accept: latch ReqA, ReqB, ReqOp, ReqM, ReqCin; clear Result; set idx=0; go to RUN.
REQ-011 In RUN, AluA = latched A[4*idx+3:4*idx], AluB = latched B[4*idx+3:4*idx], AluOp = latched Op, AluM = latched M.
REQ-012 In RUN, AluCin SHALL be latched Cin when idx=0, and the carry registered from the previous slice otherwise.
REQ-013 Each RUN edge SHALL write AluOut into Result[4*idx+3:4*idx], register AluCout as the chain carry, AND AluEq into an eq accumulator (initialised to 1 on accept), then increment idx.
REQ-014 After the edge that samples idx=SLICES-1, the block SHALL go to DONE with RespValid=1; total latency is SLICES+1 edges from accept to RespValid high.
REQ-015 In DONE, ResultCout SHALL equal the last slice's AluCout when M=0, and 0 when M=1.
REQ-016 In DONE, ResultEq SHALL equal the eq accumulator, and ResultZero SHALL be 1 exactly when Result==0.
REQ-017 RespValid and Result, ResultCout, ResultEq and ResultZero SHALL hold stable in DONE until an edge with RespReady=1, which returns the block to IDLE.
REQ-018 The response and a new request SHALL never be accepted on the same edge; minimum issue interval is SLICES+2 cycles.
REQ-019 Outside RUN, AluA, AluB, AluOp, AluM and AluCin SHALL all be 0.
REQ-020 ReqValid SHALL be ignored outside IDLE, and RespReady SHALL be ignored outside DONE.
REQ-021 Request inputs SHALL be sampled only at accept; changes to them during RUN or DONE SHALL have no effect.

Reset
REQ-022 While RST_N=0, regardless of CLK: state=IDLE, idx=0, ReqReady=1, RespValid=0, Result=0, ResultCout=0, ResultEq=0, ResultZero=0, and all Alu* outputs 0.
REQ-023 Reset asserted in RUN or DONE SHALL discard the operation; no RespValid SHALL appear for it after release.
REQ-024 After RST_N rises, the first request is acceptable on the first CLK edge.

Verification
Bench slice model: Op=1001,M=0 gives {AluCout,AluOut} = A+B+Cin; M=1 gives AluOut = A XOR B and AluCout=0; AluEq = (AluOut==4'hF).
REQ-025 Add: A=16'h00FF, B=16'h0001, Op=1001, M=0, Cin=0 -> after 5 edges, Result=16'h0100, ResultCout=0, ResultZero=0.
REQ-026 Carry out: A=16'hFFFF, B=16'h0001, add, Cin=0 -> Result=16'h0000, ResultCout=1, ResultZero=1; AluCin observed as 0,1,1,1 across the four slices.
REQ-027 Logic with equality: A=16'h1234, B=16'hEDCB, M=1 -> Result=16'hFFFF, ResultEq=1, ResultCout=0.
REQ-028 Backpressure: RespReady held 0 for 10 cycles -> RespValid and Result stay stable, ReqReady stays 0, and a second ReqValid is not accepted until 1 cycle after RespReady=1.
REQ-029 Reset mid-RUN: RST_N pulsed low at slice idx=2 -> all outputs go to reset values immediately, with no response afterward; the next request completes correctly.
REQ-030 Random back-to-back: 1000 random add and logic ops with random RespReady -> Result matches the 16-bit model, and the issue interval is never below 6 cycles.
